// File: rtl/frame_mem_reader.sv
// Reads a LEN-byte frame from the toggle-EN frame buffer, starting at word BASE, and streams it out little-endian as bytes.
// Define FRAME_MEM_READER_PREFETCH_EN to add a one-word holding register that removes the inter-word gap.
module frame_mem_reader #(
    parameter int AW   = 9,
    parameter int LENW = 12
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            START,
    input  logic [AW-1:0]   BASE,
    input  logic [LENW-1:0] LEN,
    output logic            MEM_EN,
    output logic            MEM_WR,
    output logic [AW-1:0]   MEM_ADDR,
    input  logic [31:0]     MEM_RDATA,
    output logic [7:0]      TX_DATA,
    output logic            TX_VALID,
    input  logic            TX_READY,
    output logic            TX_LAST,
    output logic            BUSY,
    output logic            DONE
);

    localparam int WCW = AW + 1;
    localparam logic [LENW-1:0] MAX_BYTES = LENW'(1 << (AW + 2));
    localparam logic [LENW-1:0] ONE       = LENW'(1);
    localparam logic [LENW-1:0] TWO       = LENW'(2);

    // The access strobe is toggled on the edge that leaves IDLE or finishes a word, so
    // WAIT is the cycle the buffer registers the word and CAP is the cycle its DOUT is valid.
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CAP,
        S_SEND
    } state_t;

    state_t           state_q, state_d;
    logic             mem_en_q, mem_en_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [AW-1:0]    next_addr_q, next_addr_d;
    logic [WCW-1:0]   fetch_left_q, fetch_left_d;
    logic [LENW-1:0]  rem_q, rem_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [31:0]      shreg_q, shreg_d;
    logic             tx_valid_q, tx_valid_d;
    logic             tx_last_q, tx_last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [LENW-1:0]  len_sat;
    logic [LENW:0]    len_plus3;
    logic [WCW-1:0]   words;
    logic             issue;

`ifdef FRAME_MEM_READER_PREFETCH_EN
    logic [31:0]      hold_q, hold_d;
    logic             hold_vld_q, hold_vld_d;
    logic [1:0]       fly_q, fly_d;
    logic             take_hold;
    logic             take_fly;
`endif

    always_comb begin
        len_sat   = (LEN > MAX_BYTES) ? MAX_BYTES : LEN;
        len_plus3 = {1'b0, len_sat} + (LENW + 1)'(3);
        words     = WCW'(len_plus3 >> 2);
    end

    always_comb begin
        state_d      = state_q;
        mem_en_d     = mem_en_q;
        mem_addr_d   = mem_addr_q;
        next_addr_d  = next_addr_q;
        fetch_left_d = fetch_left_q;
        rem_d        = rem_q;
        byte_idx_d   = byte_idx_q;
        shreg_d      = shreg_q;
        tx_valid_d   = tx_valid_q;
        tx_last_d    = tx_last_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        issue        = 1'b0;
`ifdef FRAME_MEM_READER_PREFETCH_EN
        hold_d       = hold_q;
        hold_vld_d   = hold_vld_q;
        fly_d        = (fly_q == 2'd1) ? 2'd2 : 2'd0;
        take_hold    = 1'b0;
        take_fly     = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    rem_d        = len_sat;
                    next_addr_d  = BASE;
                    fetch_left_d = words;
                    if (len_sat == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        issue   = 1'b1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                shreg_d    = MEM_RDATA;
                tx_valid_d = 1'b1;
                tx_last_d  = (rem_q == ONE);
                byte_idx_d = 2'd0;
                state_d    = S_SEND;
`ifdef FRAME_MEM_READER_PREFETCH_EN
                take_fly   = (fly_q == 2'd2);
`endif
            end
            S_SEND: begin
                if (TX_READY) begin
                    rem_d      = rem_q - ONE;
                    shreg_d    = {8'h00, shreg_q[31:8]};
                    byte_idx_d = byte_idx_q + 2'd1;
                    tx_last_d  = (rem_q == TWO);
                    if (rem_q == ONE) begin
                        tx_valid_d = 1'b0;
                        tx_last_d  = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = S_IDLE;
                    end else if (byte_idx_q == 2'd3) begin
`ifdef FRAME_MEM_READER_PREFETCH_EN
                        // Next word comes from the holding register, straight off DOUT, or must be waited for.
                        if (hold_vld_q) begin
                            shreg_d   = hold_q;
                            take_hold = 1'b1;
                        end else if (fly_q == 2'd2) begin
                            shreg_d  = MEM_RDATA;
                            take_fly = 1'b1;
                        end else if (fly_q == 2'd1) begin
                            tx_valid_d = 1'b0;
                            tx_last_d  = 1'b0;
                            state_d    = S_CAP;
                        end else begin
                            tx_valid_d = 1'b0;
                            tx_last_d  = 1'b0;
                            issue      = 1'b1;
                            state_d    = S_WAIT;
                        end
`else
                        tx_valid_d = 1'b0;
                        tx_last_d  = 1'b0;
                        issue      = 1'b1;
                        state_d    = S_WAIT;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef FRAME_MEM_READER_PREFETCH_EN
        if (take_hold) begin
            hold_vld_d = 1'b0;
        end
        if ((fly_q == 2'd2) && !take_fly) begin
            hold_d     = MEM_RDATA;
            hold_vld_d = 1'b1;
        end
        // At most one prefetch in flight, and only into an empty holding register.
        if (!issue && ((state_q == S_CAP) || (state_q == S_SEND)) && (state_d == S_SEND) &&
            (fly_d == 2'd0) && !hold_vld_d && (fetch_left_d != '0)) begin
            issue = 1'b1;
            fly_d = 2'd1;
        end
`endif

        if (issue) begin
            mem_en_d     = ~mem_en_q;
            mem_addr_d   = next_addr_d;
            next_addr_d  = next_addr_d + 1'b1;
            fetch_left_d = fetch_left_d - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            mem_en_q     <= 1'b0;
            mem_addr_q   <= '0;
            next_addr_q  <= '0;
            fetch_left_q <= '0;
            rem_q        <= '0;
            byte_idx_q   <= 2'd0;
            shreg_q      <= '0;
            tx_valid_q   <= 1'b0;
            tx_last_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef FRAME_MEM_READER_PREFETCH_EN
            hold_q       <= '0;
            hold_vld_q   <= 1'b0;
            fly_q        <= 2'd0;
`endif
        end else begin
            state_q      <= state_d;
            mem_en_q     <= mem_en_d;
            mem_addr_q   <= mem_addr_d;
            next_addr_q  <= next_addr_d;
            fetch_left_q <= fetch_left_d;
            rem_q        <= rem_d;
            byte_idx_q   <= byte_idx_d;
            shreg_q      <= shreg_d;
            tx_valid_q   <= tx_valid_d;
            tx_last_q    <= tx_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef FRAME_MEM_READER_PREFETCH_EN
            hold_q       <= hold_d;
            hold_vld_q   <= hold_vld_d;
            fly_q        <= fly_d;
`endif
        end
    end

    assign MEM_EN   = mem_en_q;
    assign MEM_WR   = 1'b0;
    assign MEM_ADDR = mem_addr_q;
    assign TX_DATA  = shreg_q[7:0];
    assign TX_VALID = tx_valid_q;
    assign TX_LAST  = tx_last_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

endmodule
